// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin two-port req/gnt/rvalid arbiter with response timeout and drain
module cache_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    output logic                    p0_error_o,
    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic                    p1_error_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_error_i,
    output logic                    timeout_o
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;
    state_t state, state_n;
    logic sel, ptr, win, gnt, resp_fire, to_fire, rv;
    logic [CW-1:0] cnt;
    always_comb begin
        win = (p0_req_i && p1_req_i) ? !ptr : p1_req_i;
        gnt = state == REQ && mem_gnt_i;
        resp_fire = state == RESP && mem_rvalid_i;
        to_fire = TIMEOUT_CYCLES != 0 && state == RESP && !mem_rvalid_i && cnt == TMAX;
        rv = resp_fire || to_fire;
        state_n = state;
        case (state)
            IDLE:    state_n = (p0_req_i || p1_req_i) ? REQ : IDLE;
            REQ:     state_n = mem_gnt_i ? RESP : REQ;
            RESP:    state_n = mem_rvalid_i ? IDLE : to_fire ? DRAIN : RESP;
            DRAIN:   state_n = mem_rvalid_i ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel <= 1'b0;
            ptr <= 1'b1;
            cnt <= '0;
            mem_addr_o <= '0;
            mem_we_o <= 1'b0;
            mem_be_o <= '0;
            mem_wdata_o <= '0;
            timeout_o <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && (p0_req_i || p1_req_i)) begin
                sel <= win;
                mem_addr_o <= win ? p1_addr_i : p0_addr_i;
                mem_we_o <= win ? p1_we_i : p0_we_i;
                mem_be_o <= win ? p1_be_i : p0_be_i;
                mem_wdata_o <= win ? p1_wdata_i : p0_wdata_i;
            end
            if (gnt) begin
                ptr <= sel;
                cnt <= '0;
            end else if (state == RESP && !mem_rvalid_i && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (to_fire) timeout_o <= 1'b1;
        end
    end
    assign mem_req_o = state == REQ;
    assign p0_gnt_o = gnt && !sel;
    assign p1_gnt_o = gnt && sel;
    assign p0_rvalid_o = rv && !sel;
    assign p1_rvalid_o = rv && sel;
    assign p0_rdata_o = (resp_fire && !sel) ? mem_rdata_i : '0;
    assign p1_rdata_o = (resp_fire && sel) ? mem_rdata_i : '0;
    assign p0_error_o = rv && !sel && (to_fire || mem_error_i);
    assign p1_error_o = rv && sel && (to_fire || mem_error_i);
endmodule
